// File: rtl/demosaic_wsum_norm.sv
// Weighted-sum normaliser for the demosaic tap multiplier: accumulates the tap products of one pixel,
// rounds, shifts by the weight scale and saturates, then buffers results in a 2-entry output FIFO.
module demosaic_wsum_norm #(
    parameter int PROD_W   = 24,
    parameter int ACC_W    = 27,
    parameter int SHIFT    = 10,
    parameter int OUT_W    = 10,
    parameter int MAX_TAPS = 8
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic [PROD_W-1:0] prod_data,
    input  logic              prod_last,
    input  logic              prod_valid,
    output logic              prod_ready,
    output logic [OUT_W-1:0]  pix_data,
    output logic              pix_sat,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              err_taps
);

    localparam int CNT_W = $clog2(MAX_TAPS + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_TAPS - 1);
    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(MAX_TAPS);
    localparam logic [ACC_W:0]   ROUND     = (ACC_W + 1)'(1) << (SHIFT - 1);

    // Valid/ready: a beat moves on a rising edge where valid && ready are both high; a producer
    // holding valid keeps its payload stable until that edge, and ready never looks at valid.

    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] tap_cnt;

    logic             norm_valid;
    logic [OUT_W:0]   norm_ent;      // {sat, data}

    logic [1:0]       fifo_count;
    logic [OUT_W:0]   ent0;          // head entry drives the pix_* outputs
    logic [OUT_W:0]   ent1;

    logic             prod_fire;
    logic             pix_fire;
    logic             norm_move;

    logic [ACC_W:0]   sum_wide;
    logic [ACC_W-1:0] total;
    logic [ACC_W:0]   rounded;
    logic [ACC_W:0]   quot;
    logic [OUT_W:0]   norm_calc;

    assign prod_ready = (2'(norm_valid) + fifo_count) < 2'd2;
    assign prod_fire  = prod_valid && prod_ready;
    assign pix_valid  = (fifo_count != 2'd0);
    assign pix_fire   = pix_valid && pix_ready;
    assign norm_move  = norm_valid && (fifo_count != 2'd2);
    assign pix_data   = ent0[OUT_W-1:0];
    assign pix_sat    = ent0[OUT_W];

    always_comb begin
        sum_wide  = {1'b0, acc} + (ACC_W + 1)'(prod_data);
        total     = sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
        // One spare bit keeps the rounding add from wrapping even on a saturated total.
        rounded   = {1'b0, total} + ROUND;
        quot      = rounded >> SHIFT;
        norm_calc = {1'b0, quot[OUT_W-1:0]};
        if (|quot[ACC_W:OUT_W]) begin
            norm_calc = {1'b1, {OUT_W{1'b1}}};
        end
    end

    // Accumulate stage and sticky tap-count error.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc      <= '0;
            tap_cnt  <= '0;
            err_taps <= 1'b0;
        end else if (prod_fire) begin
            if (prod_last) begin
                acc     <= '0;
                tap_cnt <= '0;
            end else begin
                acc <= total;
                if (tap_cnt != CNT_SAT) begin
                    tap_cnt <= tap_cnt + 1'b1;
                end
                if (tap_cnt == CNT_LIMIT) begin
                    err_taps <= 1'b1;
                end
            end
        end
    end

    // Norm slot: only refilled when empty or draining, which prod_ready guarantees.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            norm_valid <= 1'b0;
            norm_ent   <= '0;
        end else if (prod_fire && prod_last) begin
            norm_valid <= 1'b1;
            norm_ent   <= norm_calc;
        end else if (norm_move) begin
            norm_valid <= 1'b0;
        end
    end

    // Two-entry in-order output FIFO; push and pop together only happen with one entry held.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            fifo_count <= 2'd0;
            ent0       <= '0;
            ent1       <= '0;
        end else begin
            case ({norm_move, pix_fire})
                2'b10: begin
                    if (fifo_count == 2'd0) begin
                        ent0 <= norm_ent;
                    end else begin
                        ent1 <= norm_ent;
                    end
                    fifo_count <= fifo_count + 2'd1;
                end
                2'b01: begin
                    ent0       <= ent1;
                    fifo_count <= fifo_count - 2'd1;
                end
                2'b11: begin
                    ent0 <= norm_ent;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_demosaic_wsum_norm.sv
// Directed bench for demosaic_wsum_norm: rounding/saturation vectors, backpressure ordering,
// tap-count error, asynchronous reset mid-pixel and a randomised scoreboard run.
module tb_demosaic_wsum_norm;

    localparam int PROD_W = 24;
    localparam int OUT_W  = 10;
    localparam int SB_W   = OUT_W + 1;

    logic              ap_clk = 1'b0;
    logic              ap_rst_n = 1'b1;
    logic [PROD_W-1:0] prod_data = '0;
    logic              prod_last = 1'b0;
    logic              prod_valid = 1'b0;
    logic              prod_ready;
    logic [OUT_W-1:0]  pix_data;
    logic              pix_sat;
    logic              pix_valid;
    logic              pix_ready = 1'b0;
    logic              err_taps;

    int n_tests = 0;
    int n_fail  = 0;
    logic [SB_W-1:0] exp_q[$];

    demosaic_wsum_norm dut (
        .ap_clk     (ap_clk),
        .ap_rst_n   (ap_rst_n),
        .prod_data  (prod_data),
        .prod_last  (prod_last),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .pix_data   (pix_data),
        .pix_sat    (pix_sat),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .err_taps   (err_taps)
    );

    // Clock
    always #5 ap_clk = ~ap_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [SB_W-1:0] model(input logic [31:0] s);
        logic [31:0] q;
        q = (s + 32'd512) >> 10;
        if (q > 32'd1023) return {1'b1, 10'd1023};
        return {1'b0, q[9:0]};
    endfunction

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    // Present one beat and hold it until accepted; returns 1 time unit after the accepting edge.
    task automatic send_beat(input logic [PROD_W-1:0] d, input logic l);
        int guard;
        guard = 0;
        prod_data  = d;
        prod_last  = l;
        prod_valid = 1'b1;
        while (!prod_ready && guard < 100) begin
            step();
            guard++;
        end
        n_tests++;
        assert (guard < 100) else begin
            n_fail++;
            $error("FAIL send_timeout: observed %0d cycles expected < 100", guard);
        end
        step();
        prod_valid = 1'b0;
    endtask

    task automatic wait_pix(input string tag, input logic [OUT_W-1:0] ed, input logic es);
        int guard;
        guard = 0;
        pix_ready = 1'b1;
        while (!pix_valid && guard < 50) begin
            step();
            guard++;
        end
        check({tag, "_valid"}, 32'(pix_valid), 32'd1);
        check({tag, "_data"}, 32'(pix_data), 32'(ed));
        check({tag, "_sat"}, 32'(pix_sat), 32'(es));
        step();
    endtask

    // One clock with scoreboard and output-hold checking; reports whether a product beat moved.
    task automatic cycle(output logic accepted);
        logic pf, xf, held;
        logic [SB_W-1:0] got;
        logic [SB_W-1:0] exp;
        pf   = prod_valid && prod_ready;
        xf   = pix_valid && pix_ready;
        held = pix_valid && !pix_ready;
        got  = {pix_sat, pix_data};
        step();
        accepted = pf;
        if (pf) prod_valid = 1'b0;
        if (held) check("hold_stable", {20'd0, pix_valid, pix_sat, pix_data}, {20'd0, 1'b1, got});
        if (xf) begin
            n_tests++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL sb_extra: observed pixel %0d expected none", got);
            end
            if (exp_q.size() != 0) begin
                exp = exp_q.pop_front();
                check("sb_pix", 32'(got), 32'(exp));
            end
        end
    endtask

    initial begin
        logic acc_flag;
        logic seen;
        int guard;
        int b;
        logic [PROD_W-1:0] bd[$];
        logic bl[$];

        // Reset
        #1 ap_rst_n = 1'b0;
        #2;
        check("rst_pix_valid", 32'(pix_valid), 32'd0);
        check("rst_pix_data", 32'(pix_data), 32'd0);
        check("rst_pix_sat", 32'(pix_sat), 32'd0);
        check("rst_err_taps", 32'(err_taps), 32'd0);
        step();
        step();
        ap_rst_n = 1'b1;
        step();
        check("rst_prod_ready", 32'(prod_ready), 32'd1);

        // Single tap: (512+512)>>10 = 1, valid two edges after it is presented
        pix_ready = 1'b1;
        send_beat(24'd512, 1'b1);
        check("lat_valid_early", 32'(pix_valid), 32'd0);
        step();
        check("lat_valid", 32'(pix_valid), 32'd1);
        check("lat_data", 32'(pix_data), 32'd1);
        check("lat_sat", 32'(pix_sat), 32'd0);
        step();
        check("lat_popped", 32'(pix_valid), 32'd0);

        // Four taps of 256000: (1024000+512)>>10 = 1000
        for (int i = 0; i < 4; i++) send_beat(24'd256000, (i == 3));
        wait_pix("four_tap", 10'd1000, 1'b0);
        // Accumulator restarted: (2048+512)>>10 = 2
        send_beat(24'd2048, 1'b1);
        wait_pix("restart", 10'd2, 1'b0);

        // Saturation: (2000000+512)>>10 = 1953 -> clamp
        send_beat(24'd1000000, 1'b0);
        send_beat(24'd1000000, 1'b1);
        wait_pix("sat", 10'd1023, 1'b1);

        // Tap-count error: 8 non-last beats, error on the 8th, result (9+512)>>10 = 0
        for (int i = 0; i < 7; i++) send_beat(24'd1, 1'b0);
        check("err_before", 32'(err_taps), 32'd0);
        send_beat(24'd1, 1'b0);
        check("err_set", 32'(err_taps), 32'd1);
        send_beat(24'd1, 1'b1);
        check("err_sticky", 32'(err_taps), 32'd1);
        wait_pix("err_pix", 10'd0, 1'b0);
        check("err_sticky_after", 32'(err_taps), 32'd1);

        // Backpressure: two pixels fill the buffer, third waits
        pix_ready = 1'b0;
        send_beat(24'd1024, 1'b1);
        check("bp_ready_after1", 32'(prod_ready), 32'd1);
        send_beat(24'd2048, 1'b1);
        check("bp_ready_after2", 32'(prod_ready), 32'd0);
        exp_q.push_back({1'b0, 10'd1});
        exp_q.push_back({1'b0, 10'd2});
        exp_q.push_back({1'b0, 10'd3});
        prod_data  = 24'd3072;
        prod_last  = 1'b1;
        prod_valid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (prod_ready) seen = 1'b1;
            cycle(acc_flag);
        end
        check("bp_ready_held_low", 32'(seen), 32'd0);
        check("bp_head_data", 32'(pix_data), 32'd1);
        pix_ready = 1'b1;
        guard = 0;
        while ((exp_q.size() != 0 || prod_valid) && guard < 30) begin
            cycle(acc_flag);
            guard++;
        end
        check("bp_drained", 32'(exp_q.size()), 32'd0);
        check("bp_empty", 32'(pix_valid), 32'd0);

        // Random valid/ready against the reference model
        for (int p = 0; p < 30; p++) begin
            int n;
            logic [31:0] s;
            logic [PROD_W-1:0] d;
            n = $urandom_range(1, 3);
            s = 0;
            for (int t = 0; t < n; t++) begin
                d = PROD_W'($urandom_range(0, 700000));
                s = s + 32'(d);
                bd.push_back(d);
                bl.push_back(t == n - 1);
            end
            exp_q.push_back(model(s));
        end
        b = 0;
        guard = 0;
        while ((b < bd.size() || exp_q.size() != 0) && guard < 5000) begin
            if (!prod_valid && b < bd.size() && $urandom_range(0, 3) != 0) begin
                prod_data  = bd[b];
                prod_last  = bl[b];
                prod_valid = 1'b1;
            end
            pix_ready = ($urandom_range(0, 2) != 0);
            cycle(acc_flag);
            if (acc_flag) b++;
            guard++;
        end
        check("rand_done", 32'(guard < 5000), 32'd1);
        check("rand_sb_empty", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset mid-pixel with a buffered result
        pix_ready = 1'b0;
        send_beat(24'd4096, 1'b1);
        step();
        send_beat(24'd5000, 1'b0);
        send_beat(24'd5000, 1'b0);
        #3 ap_rst_n = 1'b0;
        #1;
        check("arst_pix_valid", 32'(pix_valid), 32'd0);
        check("arst_pix_data", 32'(pix_data), 32'd0);
        check("arst_pix_sat", 32'(pix_sat), 32'd0);
        check("arst_err_taps", 32'(err_taps), 32'd0);
        check("arst_prod_ready", 32'(prod_ready), 32'd1);
        step();
        ap_rst_n = 1'b1;
        send_beat(24'd1024, 1'b1);
        wait_pix("arst_pix", 10'd1, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (pix_valid) seen = 1'b1;
            step();
        end
        check("arst_no_leftover", 32'(seen), 32'd0);

        // Report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
